// File: rtl/poly_mac_datapath.sv
// Schoolbook polynomial multiplier stage: c(x) = a(x)*b(x) mod (x^N - 1), coefficients mod 2^W.
// Define NEGACYCLIC_EN to reduce mod (x^N + 1) instead (wrapped coefficient is negated).
module poly_mac_datapath #(
  parameter int N = 4,
  parameter int W = 4,
  localparam int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] a_flat,
  input  logic [N*W-1:0] b_flat,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] c_flat,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t          state_reg;
  logic [CW-1:0]   counter_reg;
  logic [W-1:0]    a_reg    [N];
  logic [W-1:0]    brot_reg [N];
  logic [W-1:0]    acc_reg  [N];

  logic [W-1:0]    a_sel;
  logic [W-1:0]    wrap_val;
  logic [W-1:0]    acc_next  [N];
  logic [W-1:0]    brot_next [N];

  assign a_sel = a_reg[counter_reg];

`ifdef NEGACYCLIC_EN
  assign wrap_val = W'(0) - brot_reg[N-1];
`else
  assign wrap_val = brot_reg[N-1];
`endif

  // One MAC lane per coefficient; BROT shifts up by one so lane j sees b[j-i] at step i.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      assign acc_next[gi] = acc_reg[gi] + W'(a_sel * brot_reg[gi]);
      if (gi == 0) begin : g_wrap
        assign brot_next[gi] = wrap_val;
      end else begin : g_shift
        assign brot_next[gi] = brot_reg[gi-1];
      end
      assign c_flat[gi*W +: W] = acc_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      counter_reg <= '0;
      for (int j = 0; j < N; j++) begin
        a_reg[j]    <= '0;
        brot_reg[j] <= '0;
        acc_reg[j]  <= '0;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            for (int j = 0; j < N; j++) begin
              a_reg[j]    <= a_flat[j*W +: W];
              brot_reg[j] <= b_flat[j*W +: W];
              acc_reg[j]  <= '0;
            end
            counter_reg <= '0;
            state_reg   <= MAC;
            in_ready    <= 1'b0;
            busy        <= 1'b1;
          end
        end
        MAC: begin
          for (int j = 0; j < N; j++) begin
            acc_reg[j]  <= acc_next[j];
            brot_reg[j] <= brot_next[j];
          end
          if (counter_reg == CW'(N-1)) begin
            counter_reg <= '0;
            state_reg   <= DONE;
            busy        <= 1'b0;
            out_valid   <= 1'b1;
          end else begin
            counter_reg <= counter_reg + 1'b1;
          end
        end
        DONE: begin
          // Accumulators stay untouched here so c_flat survives the drain.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_poly_mac_datapath.sv
// Scoreboard bench for poly_mac_datapath; expected products come from a reference
// convolution model, with the wrap sign chosen by NEGACYCLIC_EN.
module tb_poly_mac_datapath;
  localparam int N = 4;
  localparam int W = 4;
`ifdef NEGACYCLIC_EN
  localparam bit NEG = 1'b1;
`else
  localparam bit NEG = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] a_flat;
  logic [N*W-1:0] b_flat;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] c_flat;
  logic           busy;

  int check_count = 0;
  int pass_count  = 0;
  logic [N*W-1:0] sb [$];

  always #5 clk = ~clk;

  poly_mac_datapath #(.N(N), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_flat    (a_flat),
    .b_flat    (b_flat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c_flat    (c_flat),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [N*W-1:0] model(input logic [N*W-1:0] a, input logic [N*W-1:0] b);
    logic [N*W-1:0] c;
    c = '0;
    for (int j = 0; j < N; j++) begin
      logic [W-1:0] s;
      s = '0;
      for (int i = 0; i < N; i++) begin
        int k;
        bit wrapped;
        logic [W-1:0] t;
        k = j - i;
        wrapped = 1'b0;
        if (k < 0) begin
          k += N;
          wrapped = 1'b1;
        end
        t = W'(a[i*W +: W] * b[k*W +: W]);
        if (wrapped && NEG) t = W'(0) - t;
        s = s + t;
      end
      c[j*W +: W] = s;
    end
    return c;
  endfunction

  // Issue one operation, hold off the consumer for 'hold' cycles, then drain and compare.
  task automatic do_op(input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                       input logic [N*W-1:0] exp, input int hold);
    int cnt;
    logic [N*W-1:0] exp_pop;
    sb.push_back(exp);
    @(negedge clk);
    check_eq("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    a_flat   = a;
    b_flat   = b;
    @(negedge clk);
    in_valid = 1'b0;
    a_flat   = N*W'($urandom);
    b_flat   = N*W'($urandom);
    check_eq("busy_mac", busy, 1);
    check_eq("in_ready_mac", in_ready, 0);
    cnt = 0;
    while (!out_valid && cnt < 4*N) begin
      @(negedge clk);
      cnt++;
    end
    check_eq("latency", cnt, N);
    for (int h = 0; h < hold; h++) begin
      in_valid = (h == 1);
      @(negedge clk);
      in_valid = 1'b0;
      check_eq("bp_out_valid", out_valid, 1);
      check_eq("bp_in_ready", in_ready, 0);
      check_eq("bp_c_stable", c_flat, sb[0]);
    end
    out_ready = 1'b1;
    exp_pop = sb.pop_front();
    check_eq("c_flat", c_flat, exp_pop);
    $display("op a=%h b=%h c=%h exp=%h lat=%0d", a, b, c_flat, exp_pop, cnt);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("drain_out_valid", out_valid, 0);
    check_eq("drain_in_ready", in_ready, 1);
    check_eq("drain_c_hold", c_flat, exp_pop);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_flat = '0; b_flat = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_c_flat", c_flat, 0);

    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("idle_out_ready_ignored", out_valid, 0);

    do_op(16'h0011, 16'h1000, NEG ? 16'h100F : 16'h1001, 5);
    do_op(16'h1111, 16'h4321, NEG ? 16'hA2C8 : 16'hAAAA, 0);
    do_op(16'h000F, 16'hFFFF, 16'h1111, 1);
    do_op(16'h0000, 16'h9ABC, 16'h0000, 0);

    // Abort an operation with reset on its second MAC cycle.
    @(negedge clk);
    in_valid = 1'b1; a_flat = 16'h3579; b_flat = 16'h2468;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("mid_rst_in_ready", in_ready, 1);
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_c_flat", c_flat, 0);

    do_op(16'h1111, 16'h4321, model(16'h1111, 16'h4321), 0);
    for (int r = 0; r < 6; r++) begin
      logic [N*W-1:0] ra, rb;
      ra = N*W'($urandom);
      rb = N*W'($urandom);
      do_op(ra, rb, model(ra, rb), int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule
